// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample type and accumulator sizing for the FIR chain
package fir_pkg;

   localparam int SAMPLE_WIDTH = 16;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

   // Summing 2**log2 samples grows the magnitude by log2 bits.
   function automatic int acc_width(input int log2);
      return SAMPLE_WIDTH + log2;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered head, power-of-two depth
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (!do_push && do_pop) count_d = count_q - CW'(1);
      // The head register must already hold the next entry when a pop
      // exposes it, so it is reloaded from storage or bypassed from din_i.
      head_d = head_q;
      if (do_pop) begin
         if (count_q > CW'(1)) head_d = mem_q[rd_ptr_q + PW'(1)];
         else if (do_push)     head_d = din_i;
      end else if (count_q == '0 && do_push) begin
         head_d = din_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = head_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - accumulate-and-dump decimator with result FIFO; FIR_DECIMATOR_ROUND_EN selects round-half-up
module fir_decimator
   import fir_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int LOG2_DECIM = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          inValid,
   input  logic signed [WIDTH-1:0]       inSample,
   output logic                          outValid,
   input  logic                          outReady,
   output logic signed [WIDTH-1:0]       outSample,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

   localparam int DECIM = 2 ** LOG2_DECIM;
   localparam int ACC_W = acc_width(LOG2_DECIM) + WIDTH - SAMPLE_WIDTH;
   localparam int PH_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

`ifdef FIR_DECIMATOR_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(DECIM / 2);
`else
   localparam logic signed [ACC_W-1:0] RND = '0;
`endif

   logic signed [ACC_W-1:0] acc_q, acc_d, sum;
   logic [PH_W-1:0]         phase_q, phase_d;
   logic                    overflow_q, overflow_d;
   logic                    block_done, fifo_full, fifo_empty;
   logic [WIDTH-1:0]        result, head;

   always_comb begin
      sum        = acc_q + ACC_W'(inSample);
      result     = WIDTH'((sum + RND) >>> LOG2_DECIM);
      block_done = inValid && (phase_q == PH_W'(DECIM - 1));
      acc_d      = acc_q;
      phase_d    = phase_q;
      if (block_done) begin
         acc_d   = '0;
         phase_d = '0;
      end else if (inValid) begin
         acc_d   = sum;
         phase_d = phase_q + PH_W'(1);
      end
      // A full FIFO only loses the result when nothing leaves this cycle.
      overflow_d = overflow_q | (block_done & fifo_full & ~outReady);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q      <= '0;
         phase_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         phase_q    <= phase_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (block_done),
      .din_i   (result),
      .pop_i   (outReady),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifoCount)
   );

   assign outValid  = !fifo_empty;
   assign outSample = head;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - table, corner-case and randomized checks for fir_decimator
module tb_fir_decimator;
   import fir_pkg::*;

   logic          clock = 1'b0;
   logic          reset;
   logic          inValid;
   sample_t       inSample;
   logic          outValid;
   logic          outReady;
   sample_t       outSample;
   logic          overflow;
   logic [2:0]    fifoCount;

   int total = 0;
   int bad   = 0;

   fir_decimator dut (
      .clock     (clock),
      .reset     (reset),
      .inValid   (inValid),
      .inSample  (inSample),
      .outValid  (outValid),
      .outReady  (outReady),
      .outSample (outSample),
      .overflow  (overflow),
      .fifoCount (fifoCount)
   );

   always #5 clock = ~clock;

   typedef struct {
      int s0, s1, s2, s3;
      int exp_t;
      int exp_r;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      inValid = 1'b0;
      tick();
      reset   = 1'b0;
   endtask

   task automatic feed(input int s);
      inValid  = 1'b1;
      inSample = 16'(s);
      tick();
      inValid  = 1'b0;
   endtask

   function automatic int floor_div(input int s, input int d);
      int q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int ref_avg(input int s);
`ifdef FIR_DECIMATOR_ROUND_EN
      return floor_div(s + 2, 4);
`else
      return floor_div(s, 4);
`endif
   endfunction

   initial begin
      int q[$];
      int m_sum, m_phase, m_ovf, s, res;
      bit pop;

      vecs[0] = '{1, 2, 3, 4, 2, 3};
      vecs[1] = '{-1, -1, -1, -2, -2, -1};
      vecs[2] = '{-32768, -32768, -32768, -32768, -32768, -32768};
      vecs[3] = '{32767, 32767, 32767, 32767, 32767, 32767};
      vecs[4] = '{4, 8, 12, 16, 10, 10};
      vecs[5] = '{1, 1, 0, 0, 0, 1};
      vecs[6] = '{-1, 0, 0, 0, -1, 0};
      vecs[7] = '{-3, -3, -3, -3, -3, -3};

      inSample = '0;
      outReady = 1'b1;
      do_reset();
      check("reset_valid", int'(outValid), 0);
      check("reset_sample", int'(outSample), 0);
      check("reset_ovf", int'(overflow), 0);
      check("reset_count", int'(fifoCount), 0);

      // Partial block discarded by reset
      feed(100);
      feed(200);
      do_reset();
      feed(4); feed(8); feed(12);
      check("rst_mid_nopre", int'(outValid), 0);
      feed(16);
      check("rst_mid_valid", int'(outValid), 1);
      check("rst_mid_value", int'(outSample), 10);
      tick();
      check("rst_mid_drained", int'(fifoCount), 0);

      for (int i = 0; i < 8; i++) begin
         feed(vecs[i].s0); feed(vecs[i].s1); feed(vecs[i].s2); feed(vecs[i].s3);
         check($sformatf("vec%0d_valid", i), int'(outValid), 1);
         check($sformatf("vec%0d_count", i), int'(fifoCount), 1);
`ifdef FIR_DECIMATOR_ROUND_EN
         check($sformatf("vec%0d_value", i), int'(outSample), vecs[i].exp_r);
`else
         check($sformatf("vec%0d_value", i), int'(outSample), vecs[i].exp_t);
`endif
         tick();
         check($sformatf("vec%0d_popped", i), int'(outValid), 0);
      end

      // Gaps between samples
      for (int k = 0; k < 4; k++) begin
         feed(8);
         if (k < 3) begin
            tick(); tick();
            check("gap_hold", int'(outValid), 0);
         end
      end
      check("gap_valid", int'(outValid), 1);
      check("gap_value", int'(outSample), 8);
      tick();
      check("gap_single", int'(outValid), 0);

      // Backpressure and overflow
      do_reset();
      outReady = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         for (int k = 0; k < 4; k++) feed(b);
      end
      check("bp_count", int'(fifoCount), 4);
      check("bp_ovf", int'(overflow), 1);
      check("bp_hold", int'(outSample), 1);
      tick();
      check("bp_hold2", int'(outSample), 1);
      outReady = 1'b1;
      for (int b = 1; b <= 4; b++) begin
         check($sformatf("bp_out%0d", b), int'(outSample), b);
         check($sformatf("bp_valid%0d", b), int'(outValid), 1);
         tick();
      end
      check("bp_empty", int'(outValid), 0);
      check("bp_ovf_sticky", int'(overflow), 1);

      // Full with simultaneous push and pop
      do_reset();
      check("full_ovf_clr", int'(overflow), 0);
      outReady = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         for (int k = 0; k < 4; k++) feed(b);
      end
      feed(9); feed(9); feed(9);
      check("full_count", int'(fifoCount), 4);
      outReady = 1'b1;
      feed(9);
      check("full_pp_count", int'(fifoCount), 4);
      check("full_pp_ovf", int'(overflow), 0);
      check("full_pp_head", int'(outSample), 2);
      check("full_pp_o3", int'(outSample), 2); tick();
      check("full_pp_o4", int'(outSample), 3); tick();
      check("full_pp_o9a", int'(outSample), 4); tick();
      check("full_pp_o9", int'(outSample), 9); tick();
      check("full_pp_empty", int'(outValid), 0);

      // Randomized run against a queue model
      do_reset();
      q.delete();
      m_sum = 0; m_phase = 0; m_ovf = 0;
      for (int c = 0; c < 800; c++) begin
         inValid  = ($urandom_range(0, 9) < 7);
         outReady = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 7))
            0:       s = -32768;
            1:       s = 32767;
            default: s = int'($urandom_range(0, 65535)) - 32768;
         endcase
         inSample = 16'(s);
         pop = outReady && (q.size() > 0);
         if (pop) void'(q.pop_front());
         if (inValid) begin
            m_sum += s;
            m_phase++;
            if (m_phase == 4) begin
               res = ref_avg(m_sum);
               if (q.size() < 4) q.push_back(res);
               else m_ovf = 1;
               m_sum = 0;
               m_phase = 0;
            end
         end
         tick();
         check("rnd_valid", int'(outValid), (q.size() > 0) ? 1 : 0);
         check("rnd_count", int'(fifoCount), q.size());
         check("rnd_ovf", int'(overflow), m_ovf);
         if (q.size() > 0) check("rnd_sample", int'(outSample), q[0]);
      end
      inValid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
